// File: rtl/b4_sipo_rx.sv
// b4_sipo_rx -- serial-in, parallel-out receiver for the 4-bit MSB-first
// serial shifter link.
//
// Collects WIDTH serial bits (MSB first) into a word and hands it to the
// consumer through a valid/ack register. A word that completes while the
// previous one is still unacknowledged is dropped, and the sticky overrun
// flag is set.
//
// Build option: define PARITY_CHK_EN to expect one extra even-parity bit
// after the data bits. Delivery then moves to the parity-bit edge, and perr
// reports the check result for the word in dout. Without the macro, perr is
// constant 0.
//
// Parameters:
//   WIDTH   data bits per frame, 2..32
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   sin     serial data, MSB first
//   start   frame start; sin in this cycle is the MSB
//   shift   bit strobe for the remaining bits
//   dout    received word (registered)
//   dvalid  dout holds an unacknowledged word
//   dack    consumer accepts dout
//   busy    frame in progress
//   ovr     sticky overrun flag
//   perr    parity error for the word in dout
module b4_sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             start,
  input  logic             shift,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dack,
  output logic             busy,
  output logic             ovr,
  output logic             perr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH-1:0] dout_reg;
  logic             dvalid_reg, ovr_reg, perr_reg;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             pbad;

  assign shifted = {shreg_reg[WIDTH-2:0], sin};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shreg_next = shreg_reg;
    done       = 1'b0;
    word       = shifted;
    pbad       = 1'b0;
    case (state_reg)
      IDLE: begin
        // Only start opens a frame; a stray shift strobe is ignored here.
        if (start) begin
          shreg_next = shifted;
          cnt_next   = CW'(1);
          state_next = RECV;
        end
      end
      RECV: begin
        // A new start silently abandons the partial frame.
        if (start) begin
          shreg_next = shifted;
          cnt_next   = CW'(1);
        end else if (shift) begin
          shreg_next = shifted;
          if (cnt_reg == LAST_BIT) begin
`ifdef PARITY_CHK_EN
            cnt_next   = cnt_reg + CW'(1);
            state_next = PAR;
`else
            cnt_next   = '0;
            state_next = IDLE;
            done       = 1'b1;
`endif
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
`ifdef PARITY_CHK_EN
      PAR: begin
        if (start) begin
          shreg_next = shifted;
          cnt_next   = CW'(1);
          state_next = RECV;
        end else if (shift) begin
          // The data word is already complete in shreg; sin is the parity bit.
          word       = shreg_reg;
          pbad       = (^shreg_reg) ^ sin;
          done       = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shreg_reg  <= '0;
      dout_reg   <= '0;
      dvalid_reg <= 1'b0;
      ovr_reg    <= 1'b0;
      perr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      if (done) begin
        // An ack on the completion edge frees the buffer for the new word.
        if (!dvalid_reg || dack) begin
          dout_reg   <= word;
          perr_reg   <= pbad;
          dvalid_reg <= 1'b1;
        end else begin
          ovr_reg <= 1'b1;
        end
      end else if (dvalid_reg && dack) begin
        dvalid_reg <= 1'b0;
      end
    end
  end

`ifndef PARITY_CHK_EN
  // Without a parity stage, the oldest shreg bit is shifted out and never read.
  logic unused_msb;
  assign unused_msb = shreg_reg[WIDTH-1];
`endif

  assign dout   = dout_reg;
  assign dvalid = dvalid_reg;
  assign busy   = (state_reg != IDLE);
  assign ovr    = ovr_reg;
  assign perr   = perr_reg;

endmodule

// File: tb/tb_b4_sipo_rx.sv
// Directed testbench for b4_sipo_rx with WIDTH=4. It covers reset, basic
// reception, gapped strobes, overrun, ack on the completion edge, abort and
// restart, mid-frame reset, back-to-back frames and, when PARITY_CHK_EN is
// defined, the parity check.
module tb_b4_sipo_rx;

`ifdef PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0;
  logic       start = 1'b0;
  logic       shift = 1'b0;
  logic       dack = 1'b0;
  logic [3:0] dout;
  logic       dvalid, busy, ovr, perr;

  int checks = 0;
  int errors = 0;

  b4_sipo_rx #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .start(start), .shift(shift),
    .dout(dout), .dvalid(dvalid), .dack(dack), .busy(busy), .ovr(ovr),
    .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one whole frame, plus a parity bit when parity is enabled.
  // busy_low counts cycles inside the frame that showed busy=0.
  // dv_early counts cycles before completion that showed dvalid=1.
  task automatic send_frame(input logic [3:0] d, input logic pb, input int gap,
                            input logic ack_first, input logic ack_last,
                            output int busy_low, output int dv_early);
    busy_low = 0;
    dv_early = 0;
    start = 1'b1; sin = d[3]; shift = 1'b0; dack = ack_first;
    tick;
    start = 1'b0; dack = 1'b0;
    if (!busy) busy_low++;
    if (dvalid) dv_early++;
    for (int i = 2; i >= 0; i--) begin
      repeat (gap) begin
        shift = 1'b0;
        tick;
        if (!busy) busy_low++;
        if (dvalid) dv_early++;
      end
      shift = 1'b1; sin = d[i];
      if (i == 0 && !PAR_EN) dack = ack_last;
      tick;
      shift = 1'b0; dack = 1'b0;
      if (i > 0 || PAR_EN) begin
        if (!busy) busy_low++;
        if (dvalid) dv_early++;
      end
    end
    if (PAR_EN) begin
      repeat (gap) begin
        shift = 1'b0;
        tick;
        if (!busy) busy_low++;
        if (dvalid) dv_early++;
      end
      shift = 1'b1; sin = pb; dack = ack_last;
      tick;
      shift = 1'b0; dack = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; shift = 1'b1; sin = 1'b1; dack = 1'b1;
    tick; tick;
    start = 1'b0; shift = 1'b0; sin = 1'b0; dack = 1'b0;
    checks++;
    if ({dout, dvalid, busy, ovr, perr} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%b dvalid=%b busy=%b ovr=%b perr=%b, expected all 0",
               dout, dvalid, busy, ovr, perr);
    end
    rst_n = 1'b1;
    tick;
    $display("test_reset: dout=%b dvalid=%b busy=%b", dout, dvalid, busy);
  endtask

  task automatic test_basic;
    logic dv_mid, busy_mid;
    start = 1'b1; sin = 1'b1;
    tick;
    start = 1'b0; shift = 1'b1; sin = 1'b0;
    tick;
    sin = 1'b1;
    tick;
    busy_mid = busy; dv_mid = dvalid;
    sin = 1'b1;
    tick;
    if (PAR_EN) begin
      busy_mid = busy; dv_mid = dvalid;
      sin = 1'b1;
      tick;
    end
    shift = 1'b0;
    checks++;
    if (busy_mid !== 1'b1 || dv_mid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pre_edge: got busy=%b dvalid=%b, expected busy=1 dvalid=0", busy_mid, dv_mid);
    end
    checks++;
    if ({dout, dvalid, busy, ovr, perr} !== {4'b1011, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_word: got dout=%b dvalid=%b busy=%b ovr=%b perr=%b, expected 1011 1 0 0 0",
               dout, dvalid, busy, ovr, perr);
    end
    dack = 1'b1;
    tick;
    dack = 1'b0;
    checks++;
    if (dvalid !== 1'b0 || dout !== 4'b1011) begin
      errors++;
      $display("FAIL basic_ack: got dvalid=%b dout=%b, expected 0 1011", dvalid, dout);
    end
    $display("test_basic: dout=%b dvalid=%b", dout, dvalid);
  endtask

  task automatic test_gaps;
    int bl, de;
    send_frame(4'b1011, 1'b1, 3, 1'b0, 1'b0, bl, de);
    checks++;
    if (bl !== 0) begin
      errors++;
      $display("FAIL gaps_busy: got %0d cycles with busy=0, expected 0", bl);
    end
    checks++;
    if (dout !== 4'b1011 || dvalid !== 1'b1 || busy !== 1'b0 || de !== 0) begin
      errors++;
      $display("FAIL gaps_word: got dout=%b dvalid=%b busy=%b early=%0d, expected 1011 1 0 0",
               dout, dvalid, busy, de);
    end
    $display("test_gaps: dout=%b dvalid=%b", dout, dvalid);
  endtask

  task automatic test_overrun;
    int bl, de;
    send_frame(4'b0110, 1'b0, 0, 1'b0, 1'b0, bl, de);
    checks++;
    if (dout !== 4'b1011 || dvalid !== 1'b1 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drop: got dout=%b dvalid=%b ovr=%b, expected 1011 1 1", dout, dvalid, ovr);
    end
    dack = 1'b1;
    tick;
    dack = 1'b0;
    tick;
    checks++;
    if (dvalid !== 1'b0 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got dvalid=%b ovr=%b, expected 0 1", dvalid, ovr);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL overrun_reset_clear: got ovr=%b, expected 0", ovr);
    end
    $display("test_overrun: ovr after reset=%b", ovr);
  endtask

  task automatic test_ack_on_completion;
    int bl, de;
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0, bl, de);
    send_frame(4'b0110, 1'b0, 0, 1'b0, 1'b1, bl, de);
    checks++;
    if (dout !== 4'b0110 || dvalid !== 1'b1 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL ack_on_completion: got dout=%b dvalid=%b ovr=%b, expected 0110 1 0", dout, dvalid, ovr);
    end
    dack = 1'b1;
    tick;
    dack = 1'b0;
    $display("test_ack_on_completion: dout=%b dvalid=%b", dout, dvalid);
  endtask

  task automatic test_abort;
    int bl, de;
    start = 1'b1; sin = 1'b1;
    tick;
    start = 1'b0; shift = 1'b1; sin = 1'b1;
    tick;
    shift = 1'b0;
    send_frame(4'b1001, 1'b0, 0, 1'b0, 1'b0, bl, de);
    checks++;
    if (dout !== 4'b1001 || dvalid !== 1'b1 || de !== 0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: got dout=%b dvalid=%b early=%0d ovr=%b, expected 1001 1 0 0",
               dout, dvalid, de, ovr);
    end
    // Leave dvalid set and reset in the middle of a new frame.
    start = 1'b1; sin = 1'b0;
    tick;
    start = 1'b0; shift = 1'b1; sin = 1'b1;
    tick;
    shift = 1'b0; rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++;
    if ({dout, dvalid, busy, ovr, perr} !== 8'b0) begin
      errors++;
      $display("FAIL midframe_reset: got dout=%b dvalid=%b busy=%b ovr=%b perr=%b, expected all 0",
               dout, dvalid, busy, ovr, perr);
    end
    // After reset the FSM is idle, so shift strobes without start do nothing.
    shift = 1'b1; sin = 1'b1;
    repeat (5) tick;
    shift = 1'b0;
    checks++;
    if (busy !== 1'b0 || dvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_shift: got busy=%b dvalid=%b, expected 0 0", busy, dvalid);
    end
    $display("test_abort: dout=%b dvalid=%b busy=%b", dout, dvalid, busy);
  endtask

  task automatic test_back_to_back;
    int bl, de;
    send_frame(4'b1100, 1'b0, 0, 1'b0, 1'b0, bl, de);
    checks++;
    if (dout !== 4'b1100 || dvalid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got dout=%b dvalid=%b, expected 1100 1", dout, dvalid);
    end
    // Ack the first word during the start cycle of the next frame.
    send_frame(4'b0011, 1'b0, 0, 1'b1, 1'b0, bl, de);
    checks++;
    if (dout !== 4'b0011 || dvalid !== 1'b1 || ovr !== 1'b0 || de !== 0 || bl !== 0) begin
      errors++;
      $display("FAIL b2b_second: got dout=%b dvalid=%b ovr=%b early=%0d busy_low=%0d, expected 0011 1 0 0 0",
               dout, dvalid, ovr, de, bl);
    end
    dack = 1'b1;
    tick;
    dack = 1'b0;
    $display("test_back_to_back: dout=%b dvalid=%b", dout, dvalid);
  endtask

`ifdef PARITY_CHK_EN
  task automatic test_parity;
    int bl, de;
    send_frame(4'b1011, 1'b0, 1, 1'b0, 1'b0, bl, de);
    checks++;
    if (dout !== 4'b1011 || perr !== 1'b1 || dvalid !== 1'b1 || de !== 0) begin
      errors++;
      $display("FAIL parity_bad: got dout=%b perr=%b dvalid=%b early=%0d, expected 1011 1 1 0",
               dout, perr, dvalid, de);
    end
    dack = 1'b1;
    tick;
    dack = 1'b0;
    send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0, bl, de);
    checks++;
    if (dout !== 4'b1011 || perr !== 1'b0 || dvalid !== 1'b1) begin
      errors++;
      $display("FAIL parity_good: got dout=%b perr=%b dvalid=%b, expected 1011 0 1", dout, perr, dvalid);
    end
    dack = 1'b1;
    tick;
    dack = 1'b0;
    send_frame(4'b0110, 1'b1, 0, 1'b0, 1'b0, bl, de);
    checks++;
    if (dout !== 4'b0110 || perr !== 1'b1) begin
      errors++;
      $display("FAIL parity_bad2: got dout=%b perr=%b, expected 0110 1", dout, perr);
    end
    dack = 1'b1;
    tick;
    dack = 1'b0;
    $display("test_parity: dout=%b perr=%b", dout, perr);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_overrun;
    test_ack_on_completion;
    test_abort;
    test_back_to_back;
`ifdef PARITY_CHK_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
